// File: rtl/ksa2_issue_ctrl.sv
// rtl/ksa2_issue_ctrl.sv - round-robin issue controller for the pipelined SFQ Kogge-Stone adder
module ksa2_issue_ctrl #(
    parameter int W     = 2,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic         GCLK_Pad,
    input  logic         RSTn_Pad,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    output logic         add_fire,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W:0]   rsp0_data,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W:0]   rsp1_data
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] r_credit [2];
    logic          r_ptr;
    logic [LAT:0]  r_dl_vld;
    logic [LAT:0]  r_dl_id;
    logic [W:0]    r_mem [2][DEPTH];
    logic [PW-1:0] r_wr [2];
    logic [PW-1:0] r_rd [2];
    logic [CW-1:0] r_cnt [2];

    logic [1:0]    w_elig;
    logic [1:0]    w_grant;
    logic [1:0]    w_pop;
    logic [1:0]    w_push;
    logic          w_accept;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready is suppressed during reset so nothing is accepted on the reset edge.
    assign w_elig[0]  = RSTn_Pad && req0_valid && (r_credit[0] != '0);
    assign w_elig[1]  = RSTn_Pad && req1_valid && (r_credit[1] != '0);
    assign w_grant[0] = w_elig[0] && (!w_elig[1] || !r_ptr);
    assign w_grant[1] = w_elig[1] && (!w_elig[0] ||  r_ptr);
    assign w_accept   = |w_grant;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign w_pop[0]   = (r_cnt[0] != '0) && rsp0_ready;
    assign w_pop[1]   = (r_cnt[1] != '0) && rsp1_ready;
    assign w_push[0]  = r_dl_vld[LAT] && !r_dl_id[LAT];
    assign w_push[1]  = r_dl_vld[LAT] &&  r_dl_id[LAT];

    assign rsp0_valid = (r_cnt[0] != '0);
    assign rsp1_valid = (r_cnt[1] != '0);
    assign rsp0_data  = rsp0_valid ? r_mem[0][r_rd[0]] : '0;
    assign rsp1_data  = rsp1_valid ? r_mem[1][r_rd[1]] : '0;

    // Operand register: zero whenever nothing issues so the SFQ gates see no pulses.
    always_ff @(posedge GCLK_Pad) begin
        if (!RSTn_Pad || !w_accept) begin
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            add_fire <= 1'b0;
        end else if (w_grant[0]) begin
            add_a    <= req0_a;
            add_b    <= req0_b;
            add_cin  <= req0_cin;
            add_fire <= 1'b1;
        end else begin
            add_a    <= req1_a;
            add_b    <= req1_b;
            add_cin  <= req1_cin;
            add_fire <= 1'b1;
        end
    end

    // Round-robin pointer moves to the requester that lost (or was absent) after each grant.
    always_ff @(posedge GCLK_Pad) begin
        if (!RSTn_Pad) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= w_grant[0];
        end
    end

    // Delay line: stage 0 lines up with add_fire, stage LAT lines up with valid adder outputs.
    always_ff @(posedge GCLK_Pad) begin
        if (!RSTn_Pad) begin
            r_dl_vld <= '0;
            r_dl_id  <= '0;
        end else begin
            r_dl_vld <= {r_dl_vld[LAT-1:0], w_accept};
            r_dl_id  <= {r_dl_id[LAT-1:0], w_grant[1]};
        end
    end

    // Result storage writes; contents need no reset because the counts gate visibility.
    always_ff @(posedge GCLK_Pad) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr[i]] <= {add_cout, add_sum};
            end
        end
    end

    // Per-requester credits and FIFO pointers; a credit is held from accept until its result is popped.
    always_ff @(posedge GCLK_Pad) begin
        for (int i = 0; i < 2; i++) begin
            if (!RSTn_Pad) begin
                r_credit[i] <= CW'(DEPTH);
                r_wr[i]     <= '0;
                r_rd[i]     <= '0;
                r_cnt[i]    <= '0;
            end else begin
                if (w_grant[i] && !w_pop[i]) begin
                    r_credit[i] <= r_credit[i] - 1'b1;
                end else if (!w_grant[i] && w_pop[i]) begin
                    r_credit[i] <= r_credit[i] + 1'b1;
                end
                if (w_push[i]) begin
                    r_wr[i] <= next_ptr(r_wr[i]);
                end
                if (w_pop[i]) begin
                    r_rd[i] <= next_ptr(r_rd[i]);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_push[i] && w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
                assert (!(w_push[i] && !w_pop[i] && (r_cnt[i] == CW'(DEPTH))));
                assert (r_credit[i] <= CW'(DEPTH));
            end
        end
    end
endmodule

// File: tb/tb_ksa2_issue_ctrl.sv
// tb/tb_ksa2_issue_ctrl.sv - self-checking bench for ksa2_issue_ctrl with queue-based reference model
`timescale 1ns/1ps
module tb_ksa2_issue_ctrl;
    localparam int W     = 2;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         GCLK_Pad = 1'b0;
    logic         RSTn_Pad;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic [W-1:0] add_a, add_b;
    logic         add_cin, add_fire;
    logic [W-1:0] add_sum;
    logic         add_cout;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W:0]   rsp0_data, rsp1_data;

    int n_tests = 0;
    int n_fail  = 0;

    ksa2_issue_ctrl #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .GCLK_Pad(GCLK_Pad), .RSTn_Pad(RSTn_Pad),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_fire(add_fire),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data)
    );

    always #5 GCLK_Pad = ~GCLK_Pad;

    // Adder stand-in: LAT edges from operands presented to {cout,sum} valid.
    logic [W:0] pipe [LAT];
    always @(posedge GCLK_Pad) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign {add_cout, add_sum} = pipe[LAT-1];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: credits as integers, FIFOs as queues, in-flight ops as a due-time list.
    typedef struct { int id; int due; logic [W:0] res; } fl_t;
    fl_t        fl[$];
    logic [W:0] mq0[$];
    logic [W:0] mq1[$];
    int         cr0 = DEPTH, cr1 = DEPTH, ptr = 0, cyc = 0;
    logic [W-1:0] e_a = '0, e_b = '0;
    logic       e_cin = 1'b0, e_fire = 1'b0;

    function automatic bit mdl_ready(input int i);
        bit e0, e1;
        e0 = RSTn_Pad && req0_valid && (cr0 > 0);
        e1 = RSTn_Pad && req1_valid && (cr1 > 0);
        if (i == 0) return e0 && (!e1 || ptr == 0);
        return e1 && (!e0 || ptr == 1);
    endfunction

    always @(posedge GCLK_Pad) begin
        bit g0, g1, p0, p1;
        cyc++;
        if (!RSTn_Pad) begin
            cr0 = DEPTH; cr1 = DEPTH; ptr = 0;
            mq0.delete(); mq1.delete(); fl.delete();
            e_a = '0; e_b = '0; e_cin = 1'b0; e_fire = 1'b0;
        end else begin
            g0 = mdl_ready(0);
            g1 = mdl_ready(1);
            p0 = (mq0.size() > 0) && rsp0_ready;
            p1 = (mq1.size() > 0) && rsp1_ready;
            if (p0) void'(mq0.pop_front());
            if (p1) void'(mq1.pop_front());
            while (fl.size() > 0 && fl[0].due == cyc) begin
                if (fl[0].id == 0) mq0.push_back(fl[0].res);
                else               mq1.push_back(fl[0].res);
                void'(fl.pop_front());
            end
            cr0 = cr0 + int'(p0) - int'(g0);
            cr1 = cr1 + int'(p1) - int'(g1);
            if (g0) begin
                fl.push_back('{0, cyc + LAT + 1, {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin}});
                e_a = req0_a; e_b = req0_b; e_cin = req0_cin; ptr = 1;
            end else if (g1) begin
                fl.push_back('{1, cyc + LAT + 1, {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin}});
                e_a = req1_a; e_b = req1_b; e_cin = req1_cin; ptr = 0;
            end else begin
                e_a = '0; e_b = '0; e_cin = 1'b0;
            end
            e_fire = g0 | g1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge GCLK_Pad) begin
        check("req0_ready", int'(req0_ready), int'(mdl_ready(0)));
        check("req1_ready", int'(req1_ready), int'(mdl_ready(1)));
        check("add_a", int'(add_a), int'(e_a));
        check("add_b", int'(add_b), int'(e_b));
        check("add_cin", int'(add_cin), int'(e_cin));
        check("add_fire", int'(add_fire), int'(e_fire));
        check("rsp0_valid", int'(rsp0_valid), int'(mq0.size() > 0));
        check("rsp1_valid", int'(rsp1_valid), int'(mq1.size() > 0));
        check("rsp0_data", int'(rsp0_data), (mq0.size() > 0) ? int'(mq0[0]) : 0);
        check("rsp1_data", int'(rsp1_data), (mq1.size() > 0) ? int'(mq1[0]) : 0);
    end

    task automatic tick();
        @(posedge GCLK_Pad);
        #1;
    endtask

    int last, g, alt_bad, n0, n1, gaps, r1_seen, r1_bad, seen, idx, t;
    logic [W:0] exp1[$];
    logic [W:0] got1[$];

    initial begin
        RSTn_Pad = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_cin = 0;
        req1_a = 0; req1_b = 0; req1_cin = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (2) tick();
        RSTn_Pad = 1'b1;
        #1;
        check("rst_rsp0_valid", int'(rsp0_valid), 0);
        check("rst_rsp1_data", int'(rsp1_data), 0);
        check("rst_add_fire", int'(add_fire), 0);

        // Single op: 3+1+1 = 5 -> 3'b101 visible after edge k+5
        req0_valid = 1; req0_a = 3; req0_b = 1; req0_cin = 1;
        #1 check("single_ready", int'(req0_ready), 1);
        tick();
        req0_valid = 0;
        check("single_fire", int'(add_fire), 1);
        check("single_add_a", int'(add_a), 3);
        tick();
        check("single_fire_off", int'(add_fire), 0);
        repeat (3) tick();
        check("single_early", int'(rsp0_valid), 0);
        tick();
        check("single_valid", int'(rsp0_valid), 1);
        check("single_data", int'(rsp0_data), 5);
        repeat (3) tick();

        // Alternation: both valid for 8 cycles
        last = -1; alt_bad = 0; n0 = 0; gaps = 0; r1_seen = 0; r1_bad = 0;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = W'(i); req0_b = W'(i); req0_cin = 0;
            req1_a = 1; req1_b = 2; req1_cin = 0;
            #1;
            g = req0_ready ? 0 : (req1_ready ? 1 : -1);
            if (g == -1 || g == last) alt_bad++;
            if (g == 0) n0++;
            last = g;
            tick();
            if (!add_fire) gaps++;
            if (rsp1_valid) begin r1_seen++; if (rsp1_data != 3'b011) r1_bad++; end
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp1_valid) begin r1_seen++; if (rsp1_data != 3'b011) r1_bad++; end
        end
        check("alt_order", alt_bad, 0);
        check("alt_req0_count", n0, 4);
        check("alt_fire_gaps", gaps, 0);
        check("alt_req1_results", r1_seen, 4);
        check("alt_req1_data", r1_bad, 0);

        // Credit exhaustion on requester 0
        rsp0_ready = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 16; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            #1;
            n0 += int'(req0_ready); n1 += int'(req1_ready);
            tick();
        end
        check("exh_req0_accepts", n0, 4);
        check("exh_req1_served", int'(n1 > 0), 1);
        rsp0_ready = 1;
        #1 check("exh_no_credit_yet", int'(req0_ready), 0);
        tick();
        rsp0_ready = 0;
        #1 check("exh_credit_back", int'(req0_ready), 1);
        tick();
        n0 = 0;
        for (int i = 0; i < 8; i++) begin
            #1 n0 += int'(req0_ready);
            tick();
        end
        check("exh_one_more", n0, 0);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        repeat (14) tick();

        // Full FIFO: 3 held, 1 in flight, pop on the landing edge
        rsp0_ready = 0; req0_valid = 1;
        repeat (4) begin
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            tick();
        end
        req0_valid = 0;
        for (t = 0; t < 20 && mq0.size() != 3; t++) tick();
        check("ff_reach3", mq0.size(), 3);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        check("ff_model_count", mq0.size(), 3);
        check("ff_valid", int'(rsp0_valid), 1);
        req0_valid = 1;
        #1 check("ff_credit1", int'(req0_ready), 1);
        tick();
        #1 check("ff_credit0", int'(req0_ready), 0);
        req0_valid = 0;
        rsp0_ready = 1; seen = 0;
        for (int i = 0; i < 14; i++) begin
            #1 seen += int'(rsp0_valid);
            tick();
        end
        check("ff_drained", seen, 4);

        // Reset mid-flight after req0, req1, req0 accepts
        req0_valid = 1; req1_valid = 0;
        #1 check("rf_op0", int'(req0_ready), 1);
        tick();
        req1_valid = 1;
        #1 check("rf_op1", int'(req1_ready), 1);
        tick();
        #1 check("rf_op2", int'(req0_ready), 1);
        tick();
        RSTn_Pad = 0;
        #1 check("rf_rst_ready0", int'(req0_ready), 0);
        check("rf_rst_ready1", int'(req1_ready), 0);
        tick();
        RSTn_Pad = 1;
        #1 check("rf_first_req0", int'(req0_ready), 1);
        check("rf_first_req1", int'(req1_ready), 0);
        req0_valid = 0; req1_valid = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen += int'(rsp0_valid | rsp1_valid);
        end
        check("rf_no_results", seen, 0);
        rsp0_ready = 0; req0_valid = 1; n0 = 0;
        for (int i = 0; i < 6; i++) begin
            #1 n0 += int'(req0_ready);
            tick();
        end
        check("rf_credits4", n0, 4);
        req0_valid = 0; rsp0_ready = 1;
        repeat (12) tick();

        // Wrap through FIFO1 with random consumer
        idx = 0;
        for (t = 0; t < 300 && got1.size() < 10; t++) begin
            req1_valid = (idx < 10);
            if (idx == 0) begin
                req1_a = 3; req1_b = 3; req1_cin = 1;
            end else begin
                req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            end
            rsp1_ready = 1'($urandom);
            #1;
            if (req1_valid && req1_ready) begin
                exp1.push_back({1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin});
                idx++;
            end
            if (rsp1_valid && rsp1_ready) got1.push_back(rsp1_data);
            tick();
        end
        req1_valid = 0; rsp1_ready = 1;
        check("wrap_count", got1.size(), 10);
        check("wrap_first", (got1.size() > 0) ? int'(got1[0]) : -1, 7);
        seen = 0;
        for (int i = 0; i < got1.size() && i < exp1.size(); i++)
            if (got1[i] != exp1[i]) seen++;
        check("wrap_order", seen, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            rsp0_ready = ($urandom_range(3) != 0); rsp1_ready = 1'($urandom);
            tick();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (16) tick();
        check("end_rsp0_empty", int'(rsp0_valid), 0);
        check("end_rsp1_empty", int'(rsp1_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
